lot_input_cond: RTL and testbench
=================================

// Module: lot_input_cond
// PURPOSE
//  Conditions the raw board inputs for the lottery controller (Lot) and sits directly upstream of it.
//  Synchronises and debounces the three push buttons, then emits single-cycle, mutually exclusive
//  pulses on insere, fim and fim_jogo.
//  Presents a 4-bit num that is captured in the same cycle as each insere pulse.
// PARAMETERS
//  DEBOUNCE_CYC  500000  stable cycles required before a level change is accepted (10 ms @ 50 MHz)
//  CNT_W         19      width of each debounce counter; must satisfy 2**CNT_W > DEBOUNCE_CYC
//  BTN_ACT_LOW   1       1: raw buttons are active-low (DE2 KEY); 0: active-high
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high reset
//  key_ins    in   1  raw "insert number" button
//  key_fim    in   1  raw "end of bet" button
//  key_fj     in   1  raw "end of game" button
//  sw_num     in   4  raw switch value of the number being bet
//  insere     out  1  one-cycle pulse: number accepted
//  fim        out  1  one-cycle pulse: bet finished
//  fim_jogo   out  1  one-cycle pulse: game finished
//  num        out  4  registered number, valid from the insere cycle until the next insere
//  num_err    out  1  one-cycle pulse: rejected number (only when NUM_CHECK_EN is defined)
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0; every button FSM goes to IDLE; counters 0;
//    synchroniser flops load the inactive level.
//  - Each raw input passes through a 2-flop synchroniser; BTN_ACT_LOW inversion is applied after sync.
//  - Per-button FSM, counter cnt:
//    IDLE     : when sync=1, cnt<=0 and go to P_WAIT.
//    P_WAIT   : sync=0 -> IDLE. Otherwise cnt++; when cnt==DEBOUNCE_CYC-1, raise req and go to HELD.
//    HELD     : when sync=0, cnt<=0 and go to R_WAIT.
//    R_WAIT   : sync=1 -> HELD. Otherwise cnt++; when cnt==DEBOUNCE_CYC-1, go to IDLE.
//  - req is a one-cycle signal in the P_WAIT->HELD cycle. Output pulses are registered, so an output
//    is high 1 cycle after req. Total latency from a clean press edge = 2 sync + DEBOUNCE_CYC + 1.
//  - Holding a button gives exactly one pulse; there is no auto-repeat.
//  - Glitches shorter than DEBOUNCE_CYC produce no pulse.
//  - Simultaneous req: priority fim_jogo > fim > insere. Only the winner pulses. A loser's req is
//    dropped, not queued, and its FSM still enters HELD, so no late pulse appears.
//  - num <= synchronised sw_num in the cycle insere is registered, and holds otherwise.
//    sw_num changes never affect num between insere pulses.
//  - Counters saturate structurally; a wrap is impossible because a state exit occurs at DEBOUNCE_CYC-1.
//  - Reset mid-press: FSM returns to IDLE. A button still held after release of reset must re-qualify
//    for a full DEBOUNCE_CYC before it generates a pulse.
// CONFIGURATION
//  NUM_CHECK_EN defined:
//    - An insere winner with sync sw_num > 9 produces no insere pulse, leaves num unchanged, and
//      pulses num_err for 1 cycle instead.
//  NUM_CHECK_EN undefined:
//    - All values 0..15 are passed through.
//    - num_err is tied to 0.
// STRUCTURE
//  - Shared package lot_pkg:
//    - debounce state encoding (IDLE, P_WAIT, HELD, R_WAIT; 2 bits)
//    - DEBOUNCE_CYC default
//    - NUM_MAX = 9
//  - Sub-module lot_debounce: one instance per button, containing the synchroniser, the FSM, cnt and
//    the req output.
//  - Top level contains the priority arbiter, the output pulse registers, the num register and the
//    optional range check.
// TESTING  (DEBOUNCE_CYC=4, BTN_ACT_LOW=1)
//  1. Reset asserted mid-cycle -> outputs 0 immediately. Release, then key_ins low for 20 cycles ->
//     insere high for exactly 1 cycle, 7 cycles after the edge.
//  2. sw_num=4'd7, then key_ins press -> num==7 in the insere cycle. Change sw_num to 3 with no press
//     -> num stays 7.
//  3. key_fim bounce: low 2, high 1, low 10 cycles -> exactly one fim pulse, timed from the last
//     falling edge.
//  4. key_ins and key_fj pressed on the same cycle -> only fim_jogo pulses. No insere pulse follows
//     while both are held or after their release.
//  5. key_ins held 100 cycles -> one insere pulse. Release with a 2-cycle high glitch, then press
//     again -> a second pulse only after the release qualifies.
//  6. NUM_CHECK_EN: sw_num=4'd12 plus a press -> num_err pulse, no insere, num unchanged.
//     Without the macro -> insere pulses and num==12.

Source files
------------

// File: rtl/lot_pkg.sv
// Shared definitions for the Lot input conditioning slice: debounce FSM
// state encoding, default debounce length and the largest legal bet number.
package lot_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        P_WAIT = 2'd1,
        HELD   = 2'd2,
        R_WAIT = 2'd3
    } deb_state_t;

    // 10 ms at 50 MHz
    localparam int DEBOUNCE_CYC_DEF = 500000;

    localparam logic [3:0] NUM_MAX = 4'd9;

endpackage

// File: rtl/lot_debounce.sv
// One push-button conditioner: 2-flop synchroniser, polarity fix-up and a
// press/release qualifying FSM. req is high for the single cycle in which a
// press has been stable for DEBOUNCE_CYC cycles (P_WAIT -> HELD).
module lot_debounce
    import lot_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int CNT_W        = 19,
    parameter int BTN_ACT_LOW  = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic req
);

    // Raw level of a released button
    localparam logic IDLE_LVL = (BTN_ACT_LOW != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             act;
    deb_state_t       state;
    deb_state_t       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Synchroniser loads the released level so a held key must re-qualify after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= IDLE_LVL;
            sync_p1 <= IDLE_LVL;
        end else begin
            sync_p0 <= key;
            sync_p1 <= sync_p0;
        end
    end

    // Polarity is normalised after synchronisation: act=1 means pressed
    assign act = sync_p1 ^ IDLE_LVL;

    // FSM state and qualification counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; the counter is never incremented past CNT_LAST, so it cannot wrap
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req       = 1'b0;
        case (state)
            IDLE: begin
                if (act) begin
                    cnt_nxt   = '0;
                    state_nxt = P_WAIT;
                end
            end
            P_WAIT: begin
                if (!act) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    req       = 1'b1;
                    state_nxt = HELD;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!act) begin
                    cnt_nxt   = '0;
                    state_nxt = R_WAIT;
                end
            end
            R_WAIT: begin
                if (act) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/lot_input_cond.sv
// Input conditioning in front of the Lot controller: three debounced buttons
// arbitrated into mutually exclusive one-cycle pulses (fim_jogo > fim > insere)
// and a bet number register captured with each insere pulse.
// Optional macro NUM_CHECK_EN: numbers above NUM_MAX are rejected with a
// num_err pulse instead of insere; otherwise num_err is tied low.
module lot_input_cond
    import lot_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int CNT_W        = 19,
    parameter int BTN_ACT_LOW  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_ins,
    input  logic       key_fim,
    input  logic       key_fj,
    input  logic [3:0] sw_num,
    output logic       insere,
    output logic       fim,
    output logic       fim_jogo,
    output logic [3:0] num,
    output logic       num_err
);

    logic       req_ins;
    logic       req_fim;
    logic       req_fj;
    logic       win_ins;
    logic       win_fim;
    logic       win_fj;
    logic       take_ins;
    logic [3:0] sw_p0;
    logic [3:0] sw_p1;

    lot_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W),
        .BTN_ACT_LOW  (BTN_ACT_LOW)
    ) u_deb_ins (
        .clk   (clk),
        .reset (reset),
        .key   (key_ins),
        .req   (req_ins)
    );

    lot_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W),
        .BTN_ACT_LOW  (BTN_ACT_LOW)
    ) u_deb_fim (
        .clk   (clk),
        .reset (reset),
        .key   (key_fim),
        .req   (req_fim)
    );

    lot_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .CNT_W        (CNT_W),
        .BTN_ACT_LOW  (BTN_ACT_LOW)
    ) u_deb_fj (
        .clk   (clk),
        .reset (reset),
        .key   (key_fj),
        .req   (req_fj)
    );

    // Switch synchroniser; num only ever samples the second stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_p0 <= 4'd0;
            sw_p1 <= 4'd0;
        end else begin
            sw_p0 <= sw_num;
            sw_p1 <= sw_p0;
        end
    end

    // Fixed-priority arbiter; losing requests are simply dropped
    always_comb begin
        win_fj  = req_fj;
        win_fim = req_fim & ~req_fj;
        win_ins = req_ins & ~req_fim & ~req_fj;
    end

`ifdef NUM_CHECK_EN
    logic num_ok;
    assign num_ok   = (sw_p1 <= NUM_MAX);
    assign take_ins = win_ins & num_ok;

    // Rejected number pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            num_err <= 1'b0;
        end else begin
            num_err <= win_ins & ~num_ok;
        end
    end
`else
    assign take_ins = win_ins;
    assign num_err  = 1'b0;
`endif

    // Registered output pulses and the bet number captured alongside insere
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            insere   <= 1'b0;
            fim      <= 1'b0;
            fim_jogo <= 1'b0;
            num      <= 4'd0;
        end else begin
            insere   <= take_ins;
            fim      <= win_fim;
            fim_jogo <= win_fj;
            if (take_ins) begin
                num <= sw_p1;
            end
        end
    end

endmodule

// File: tb/tb_lot_input_cond.sv
// Bench for lot_input_cond with DEBOUNCE_CYC=4, active-low buttons.
module tb_lot_input_cond;

    logic       clk;
    logic       reset;
    logic       key_ins;
    logic       key_fim;
    logic       key_fj;
    logic [3:0] sw_num;
    logic       insere;
    logic       fim;
    logic       fim_jogo;
    logic [3:0] num;
    logic       num_err;

    int n_chk = 0;
    int n_err = 0;

    int tot_ins = 0;
    int tot_fim = 0;
    int tot_fj  = 0;
    int tot_err = 0;
    int overlap = 0;

    typedef struct {
        logic       ins;
        logic       fm;
        logic       fj;
        logic [3:0] sw;
        int         exp_ins;
        int         exp_fim;
        int         exp_fj;
        int         exp_err;
        logic [3:0] exp_num;
    } vec_t;

    vec_t vecs[11];

    lot_input_cond #(
        .DEBOUNCE_CYC (4),
        .CNT_W        (3),
        .BTN_ACT_LOW  (1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .key_ins  (key_ins),
        .key_fim  (key_fim),
        .key_fj   (key_fj),
        .sw_num   (sw_num),
        .insere   (insere),
        .fim      (fim),
        .fim_jogo (fim_jogo),
        .num      (num),
        .num_err  (num_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters and exclusivity monitor
    always @(negedge clk) begin
        if (insere === 1'b1)   tot_ins++;
        if (fim === 1'b1)      tot_fim++;
        if (fim_jogo === 1'b1) tot_fj++;
        if (num_err === 1'b1)  tot_err++;
        if ((32'(insere) + 32'(fim) + 32'(fim_jogo) + 32'(num_err)) > 1) overlap++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int first;
        int b_ins, b_fim, b_fj, b_err;
        logic [3:0] num_at;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'd5,  1, 0, 0, 0, 4'd5};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 4'd2,  0, 1, 0, 0, 4'd5};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 4'd2,  0, 0, 1, 0, 4'd5};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'd9,  0, 0, 1, 0, 4'd5};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 4'd1,  0, 1, 0, 0, 4'd5};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 4'd1,  0, 0, 1, 0, 4'd5};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 4'd1,  0, 0, 1, 0, 4'd5};
`ifdef NUM_CHECK_EN
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd12, 0, 0, 0, 1, 4'd5};
`else
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'd12, 1, 0, 0, 0, 4'd12};
`endif
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 4'd0,  1, 0, 0, 0, 4'd0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'd9,  1, 0, 0, 0, 4'd9};
`ifdef NUM_CHECK_EN
        vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd15, 0, 0, 0, 1, 4'd9};
`else
        vecs[10] = '{1'b1, 1'b0, 1'b0, 4'd15, 1, 0, 0, 0, 4'd15};
`endif

        reset   = 1'b1;
        key_ins = 1'b1;
        key_fim = 1'b1;
        key_fj  = 1'b1;
        sw_num  = 4'd0;

        // Reset state
        #12;
        check("rst_insere", 32'(insere), 0);
        check("rst_fim", 32'(fim), 0);
        check("rst_fim_jogo", 32'(fim_jogo), 0);
        check("rst_num", 32'(num), 0);
        check("rst_num_err", 32'(num_err), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(3);

        // Press latency from a clean edge
        b_ins = tot_ins;
        key_ins = 1'b0;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (insere === 1'b1 && first < 0) first = i;
        end
        check("t1_latency", 32'(first), 7);
        check("t1_count", 32'(tot_ins - b_ins), 1);
        key_ins = 1'b1;
        tick(12);

        // num captured with insere, then held against switch changes
        sw_num = 4'd7;
        tick(4);
        key_ins = 1'b0;
        num_at = 4'hx;
        for (int i = 1; i <= 12; i++) begin
            tick(1);
            if (insere === 1'b1) num_at = num;
        end
        check("t2_num_at_insere", 32'(num_at), 7);
        key_ins = 1'b1;
        tick(12);
        sw_num = 4'd3;
        tick(10);
        check("t2_num_hold", 32'(num), 7);

        // Async reset while a key is held; the key must re-qualify afterwards
        key_ins = 1'b0;
        tick(12);
        check("t1_num_before_rst", 32'(num), 3);
        #3;
        reset = 1'b1;
        #1;
        check("t1_async_num", 32'(num), 0);
        check("t1_async_insere", 32'(insere), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        b_ins = tot_ins;
        first = -1;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (insere === 1'b1 && first < 0) first = i;
        end
        check("t1_requal_latency", 32'(first), 7);
        check("t1_requal_count", 32'(tot_ins - b_ins), 1);
        key_ins = 1'b1;
        tick(12);

        // Bounce on key_fim: low 2, high 1, low 10
        b_fim = tot_fim;
        key_fim = 1'b0;
        tick(2);
        key_fim = 1'b1;
        tick(1);
        key_fim = 1'b0;
        first = -1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (fim === 1'b1 && first < 0) first = i;
        end
        check("t3_latency", 32'(first), 7);
        key_fim = 1'b1;
        tick(12);
        check("t3_count", 32'(tot_fim - b_fim), 1);

        // Long hold, release glitch, then a real release and press
        b_ins = tot_ins;
        key_ins = 1'b0;
        tick(100);
        check("t5_hold_count", 32'(tot_ins - b_ins), 1);
        b_ins = tot_ins;
        key_ins = 1'b1;
        tick(2);
        key_ins = 1'b0;
        tick(20);
        check("t5_glitch_count", 32'(tot_ins - b_ins), 0);
        key_ins = 1'b1;
        tick(10);
        b_ins = tot_ins;
        key_ins = 1'b0;
        tick(12);
        check("t5_repress_count", 32'(tot_ins - b_ins), 1);
        key_ins = 1'b1;
        tick(12);

        // Table: single and simultaneous presses, number boundaries
        for (int v = 0; v < 11; v++) begin
            sw_num = vecs[v].sw;
            tick(4);
            b_ins = tot_ins;
            b_fim = tot_fim;
            b_fj  = tot_fj;
            b_err = tot_err;
            key_ins = ~vecs[v].ins;
            key_fim = ~vecs[v].fm;
            key_fj  = ~vecs[v].fj;
            tick(15);
            key_ins = 1'b1;
            key_fim = 1'b1;
            key_fj  = 1'b1;
            tick(15);
            check($sformatf("vec%0d_insere", v), 32'(tot_ins - b_ins), 32'(vecs[v].exp_ins));
            check($sformatf("vec%0d_fim", v), 32'(tot_fim - b_fim), 32'(vecs[v].exp_fim));
            check($sformatf("vec%0d_fim_jogo", v), 32'(tot_fj - b_fj), 32'(vecs[v].exp_fj));
            check($sformatf("vec%0d_num_err", v), 32'(tot_err - b_err), 32'(vecs[v].exp_err));
            check($sformatf("vec%0d_num", v), 32'(num), 32'(vecs[v].exp_num));
        end

        check("pulses_exclusive", 32'(overlap), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
